bypass_ctrl: RTL

Decode-stage hazard controller that drives the register file's bypass enables and the pipeline stall. It keeps a three-entry shadow pipeline (EX, MEM, WB) of in-flight destination registers. Each cycle it compares decode's source registers against that pipeline and emits one-hot forwarding selects per operand. It detects load-use hazards, requests a one-cycle stall and bubble, and counts stall cycles for performance monitoring.

---
 rtl/bypass_ctrl_if.sv | 32 +++
 rtl/bypass_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/bypass_ctrl_if.sv
// Decode-to-hazard-controller bundle: decode operand/destination info in,
// forwarding selects, stall and performance counters out.
interface bypass_ctrl_if #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 32
);
  logic                 D_valid;
  logic [ADDR_SIZE-1:0] D_ra;
  logic [ADDR_SIZE-1:0] D_rb;
  logic                 D_use_ra;
  logic                 D_use_rb;
  logic [ADDR_SIZE-1:0] D_rd;
  logic                 D_we;
  logic                 D_ld;
  logic                 flush;
  logic [1:0]           EX_D_bp;
  logic [1:0]           MEM_D_bp;
  logic [1:0]           WB_D_bp;
  logic                 D_stall;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, flush,
    input  EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, flush,
    output EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/bypass_ctrl.sv
// Decode-stage hazard controller: shadows EX/MEM/WB destinations, drives
// per-operand forwarding selects, load-use stall and stall/flush counters.
module bypass_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  bypass_ctrl_if.slave bus
);

  typedef struct packed {
    logic                 v;
    logic [ADDR_SIZE-1:0] rd;
    logic                 we;
    logic                 ld;
  } entry_t;

  entry_t           ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [3:0]       ra_res, rb_res;
  logic             lu, stall;

  function automatic logic hits(entry_t e, logic [ADDR_SIZE-1:0] src,
                                logic use_src, logic valid);
    return e.v & e.we & (e.rd != '0) & (e.rd == src) & use_src & valid;
  endfunction

  // Result bits {load-use, EX, MEM, WB}; a load in EX blocks older stages.
  function automatic logic [3:0] resolve(entry_t ex, entry_t mem, entry_t wb,
                                         logic [ADDR_SIZE-1:0] src,
                                         logic use_src, logic valid);
    logic [3:0] r;
    r = 4'b0000;
    if (hits(ex, src, use_src, valid))
      r = ex.ld ? 4'b1000 : 4'b0100;
    else if (hits(mem, src, use_src, valid))
      r = 4'b0010;
    else if (hits(wb, src, use_src, valid))
      r = 4'b0001;
    return r;
  endfunction

  always_comb begin
    ra_res = resolve(ex_q, mem_q, wb_q, bus.D_ra, bus.D_use_ra, bus.D_valid);
    rb_res = resolve(ex_q, mem_q, wb_q, bus.D_rb, bus.D_use_rb, bus.D_valid);
    lu     = ra_res[3] | rb_res[3];
    stall  = lu & ~bus.flush;
    ex_d   = '0;
    if (bus.D_valid && !bus.flush && !stall)
      ex_d = '{v: 1'b1, rd: bus.D_rd, we: bus.D_we, ld: bus.D_ld};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus.flush)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.EX_D_bp   = {ra_res[2], rb_res[2]};
  assign bus.MEM_D_bp  = {ra_res[1], rb_res[1]};
  assign bus.WB_D_bp   = {ra_res[0], rb_res[0]};
  assign bus.D_stall   = stall;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
